// File: rtl/spi_core_pkg.sv
// Shared definitions for the SPI controller core.
//   state_t        : transfer FSM states (IDLE, LEAD, SHIFT, TRAIL)
//   DATA_WIDTH_MAX : longest transfer the 5-bit length field can describe
//   XFER_CNT_W     : width of the completed-transfer counter
package spi_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_TRAIL = 2'd3
  } state_t;

  localparam int DATA_WIDTH_MAX = 32;
  localparam int XFER_CNT_W     = 16;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK half-period timer.
// Emits a one-cycle tick every (div+1) cycles while en is high. The count
// restarts from zero whenever en drops or rst is asserted, so the first tick
// after enabling arrives exactly (div+1) cycles later.
//   clk  : clock
//   rst  : synchronous active-high reset
//   en   : run enable
//   div  : half-period minus one
//   tick : one-cycle pulse at the end of each half-period
module spi_clk_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt;

  assign tick = en && (cnt == div);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_controller_core.sv
// SPI mode-0 controller core.
// Shifts an N-bit word (N = cfg_nbits+1) MSB-first on spi_mosi while
// capturing spi_miso, framed by spi_cs_n. Each SCLK half-period lasts
// H = cfg_div+1 cycles; chip select stays low for a lead half-period,
// 2N SCLK half-periods and a trail half-period.
//   S_AXI_ACLK / S_AXI_ARESET : clock, synchronous active-high reset
//   start, abort              : one-cycle control requests
//   tx_data, cfg_nbits, cfg_div : word and configuration, latched at start
//   busy, rx_data, rx_valid, xfer_count : status towards register interface
//   spi_sclk, spi_mosi, spi_cs_n, spi_miso : SPI pins
module spi_controller_core
  import spi_core_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESET,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic [4:0]            cfg_nbits,
  input  logic [DIV_WIDTH-1:0]  cfg_div,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic [XFER_CNT_W-1:0] xfer_count,
  output logic                  spi_sclk,
  output logic                  spi_mosi,
  output logic                  spi_cs_n,
  input  logic                  spi_miso
);

  state_t                state;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic [DATA_WIDTH-1:0] rx_sh;
  logic [4:0]            bit_idx;
  logic [DIV_WIDTH-1:0]  div_lat;
  logic                  last_half;
  logic                  gen_en;
  logic                  tick;

  assign busy   = (state != ST_IDLE);
  assign gen_en = (state != ST_IDLE);

  spi_clk_gen #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_clk_gen (
    .clk (S_AXI_ACLK),
    .rst (S_AXI_ARESET),
    .en  (gen_en),
    .div (div_lat),
    .tick(tick)
  );

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state      <= ST_IDLE;
      tx_sh      <= '0;
      rx_sh      <= '0;
      bit_idx    <= '0;
      div_lat    <= '0;
      last_half  <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      xfer_count <= '0;
      spi_sclk   <= 1'b0;
      spi_mosi   <= 1'b0;
      spi_cs_n   <= 1'b1;
    end else begin
      rx_valid <= 1'b0;
      if (abort && (state != ST_IDLE)) begin
        state    <= ST_IDLE;
        spi_cs_n <= 1'b1;
        spi_sclk <= 1'b0;
        spi_mosi <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;
            spi_cs_n <= 1'b1;
            if (start && !abort) begin
              tx_sh     <= tx_data;
              bit_idx   <= cfg_nbits;
              div_lat   <= cfg_div;
              // Cleared so bits above the transfer length read back as zero.
              rx_sh     <= '0;
              last_half <= 1'b0;
              spi_mosi  <= tx_data[cfg_nbits];
              spi_cs_n  <= 1'b0;
              state     <= ST_LEAD;
            end
          end
          ST_LEAD: begin
            // The lead half-period ends with the first SCLK rising edge.
            if (tick) begin
              spi_sclk <= 1'b1;
              rx_sh    <= {rx_sh[DATA_WIDTH-2:0], spi_miso};
              state    <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            if (tick) begin
              if (spi_sclk) begin
                // Falling edge: advance MOSI unless the last bit is out,
                // in which case the low half that follows is the final one.
                spi_sclk <= 1'b0;
                if (bit_idx == 5'd0) begin
                  last_half <= 1'b1;
                end else begin
                  bit_idx  <= bit_idx - 5'd1;
                  spi_mosi <= tx_sh[bit_idx - 5'd1];
                end
              end else if (last_half) begin
                state <= ST_TRAIL;
              end else begin
                spi_sclk <= 1'b1;
                rx_sh    <= {rx_sh[DATA_WIDTH-2:0], spi_miso};
              end
            end
          end
          ST_TRAIL: begin
            if (tick) begin
              state      <= ST_IDLE;
              spi_cs_n   <= 1'b1;
              spi_mosi   <= 1'b0;
              rx_data    <= rx_sh;
              rx_valid   <= 1'b1;
              xfer_count <= xfer_count + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/spi_controller_core.md
SPI_CONTROLLER_CORE -- requirements
Module: spi_controller_core

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the maximum shift length in bits.
REQ-002 SHALL have parameter DIV_WIDTH, default 16, giving the width of the SCLK half-period divider.
REQ-003 S_AXI_ACLK  in  1  single clock; all logic is on the rising edge.
REQ-004 S_AXI_ARESET  in  1  reset, synchronous and active-high.
REQ-005 start  in  1  one-cycle request from the register interface to begin a transfer.
REQ-006 abort  in  1  one-cycle request to terminate any transfer in progress.
REQ-007 tx_data  in  DATA_WIDTH  word to shift out, MSB-first, right-aligned.
REQ-008 cfg_nbits  in  5  transfer length minus one; N = cfg_nbits+1 (1..32).
REQ-009 cfg_div  in  DIV_WIDTH  half-period H = cfg_div+1 clock cycles.
REQ-010 busy  out  1  high while a transfer is active.
REQ-011 rx_data  out  DATA_WIDTH  last received word, right-aligned, upper bits zero.
REQ-012 rx_valid  out  1  one-cycle pulse when rx_data updates.
REQ-013 xfer_count  out  16  completed-transfer counter, wrapping.
REQ-014 spi_sclk / spi_mosi / spi_cs_n  out  1 each  SPI mode 0 pins; spi_miso  in  1.

Function
REQ-015 States SHALL be IDLE, LEAD, SHIFT, TRAIL; busy = (state != IDLE).
REQ-016 In IDLE, start with abort low SHALL latch tx_data, N and H, and enter LEAD on the next edge.
REQ-017 start SHALL be ignored when busy; the latched word and configuration SHALL NOT change mid-transfer.
REQ-018 LEAD: cs_n=0, sclk=0, mosi=tx bit N-1 for H cycles; then enter SHIFT.
REQ-019 SHIFT: sclk SHALL toggle every H cycles, for 2N half-periods, starting with a rising edge.
REQ-020 MISO SHALL be sampled at each sclk rising edge into the LSB of the shift register.
REQ-021 MOSI SHALL advance to the next lower bit at each sclk falling edge except the last.
REQ-022 TRAIL: sclk=0, cs_n=0 for H cycles; then enter IDLE, with cs_n=1, rx_data updated, a one-cycle rx_valid pulse, and xfer_count incremented in the same cycle.
REQ-023 cs_n low duration SHALL equal exactly (2N+2)*H cycles.
REQ-024 xfer_count SHALL wrap from 0xFFFF to 0x0000.
REQ-025 abort in any non-IDLE state SHALL enter IDLE on the next edge: cs_n=1, sclk=0, mosi=0, no rx_valid, rx_data and xfer_count unchanged.
REQ-026 start and abort asserted together in IDLE: abort wins and no transfer begins.
REQ-027 In IDLE, mosi SHALL be 0 and sclk SHALL be 0.

Reset
REQ-028 On reset, state=IDLE, cs_n=1, sclk=0, mosi=0, busy=0, rx_valid=0, rx_data=0, xfer_count=0, and all dividers and bit counters =0.
REQ-029 Reset mid-transfer SHALL take effect on the next edge and override start/abort; no rx_valid SHALL be produced.

Structure
REQ-030 Package spi_core_pkg SHALL hold the state enum and the constants DATA_WIDTH_MAX=32 and XFER_CNT_W=16.
REQ-031 Sub-module spi_clk_gen SHALL produce a one-cycle tick every H cycles while enabled; it SHALL clear on disable or reset.

Verification
REQ-032 cfg_div=0, cfg_nbits=7, tx=0xA5, miso looped from mosi -> cs_n low 18 cycles, rx_data=0x000000A5, one rx_valid, xfer_count=1.
REQ-033 cfg_div=3, cfg_nbits=31, tx=0xDEADBEEF, miso=1 -> sclk period 8 cycles, 32 rising edges, cs_n low 264 cycles, rx_data=0xFFFFFFFF.
REQ-034 start pulse with tx=0x12 during an active 0xA5 transfer -> ignored; mosi stream and rx_data reflect 0xA5 only; xfer_count +1.
REQ-035 abort at the 5th rising edge of an 8-bit transfer -> next cycle cs_n=1, sclk=0, busy=0; no rx_valid; rx_data and xfer_count unchanged.
REQ-036 Reset asserted mid-SHIFT -> next cycle all outputs at REQ-028 values; a subsequent start completes normally.
REQ-037 Preload xfer_count to 0xFFFF via repeated transfers, then one more transfer -> xfer_count=0x0000 with rx_valid.
